// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit.
// Stage names and the control bundle seen by the datapath.
package pipe_ctrl_pkg;

  localparam int PIPE_NSTAGE = 5;

  typedef enum logic [2:0] {
    STG_IF,
    STG_ID,
    STG_EX,
    STG_MEM,
    STG_WB
  } stage_idx_t;

  typedef struct packed {
    logic [PIPE_NSTAGE-1:0] valid;
    logic [PIPE_NSTAGE-1:0] load_en;
    logic [PIPE_NSTAGE-1:0] fire;
    logic [PIPE_NSTAGE-1:0] kill;
  } pipe_ctrl_t;

endpackage

// File: rtl/pipe_ctrl_perf_counter.sv
// Wrapping event counter for pipeline statistics.
// Clears on synchronous active-low reset.
module perf_counter #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_cnt;

  // count one per cycle with inc high, wrap naturally
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign count = r_cnt;

endmodule

// File: rtl/pipe_ctrl.sv
// Elastic per-stage valid/fire control for the in-order pipe.
// Control outputs are combinational from inputs and valid bits.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGE = PIPE_NSTAGE,
  parameter int CNT_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NSTAGE-1:0] stage_busy,
  input  logic [NSTAGE-1:0] hold_req,
  input  logic [NSTAGE-1:0] flush_req,
  output logic [NSTAGE-1:0] stage_valid,
  output logic [NSTAGE-1:0] load_en,
  output logic [NSTAGE-1:0] fire,
  output logic [NSTAGE-1:0] kill,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int FK_W = $clog2(NSTAGE);

  logic [NSTAGE-1:0] r_v;
  logic [NSTAGE-1:0] w_done;
  logic [NSTAGE-1:0] w_fire;
  logic [NSTAGE-1:0] w_ready;
  logic [NSTAGE-1:0] w_kill;
  logic [NSTAGE-1:0] w_load;
  logic [FK_W-1:0]   w_fk;
  logic              w_flush_act;
  logic              w_stall_inc;

  // completion and fire chain, oldest stage first
  always_comb begin
    w_done = r_v & ~stage_busy & ~hold_req;
    w_fire = '0;
    w_fire[NSTAGE-1] = w_done[NSTAGE-1];
    for (int i = NSTAGE - 2; i >= 0; i--) begin
      w_fire[i] = w_done[i] & (~r_v[i+1] | w_fire[i+1]);
    end
    w_ready = ~r_v | w_fire;
  end

  // pick the oldest valid stage requesting a flush
  always_comb begin
    w_fk = '0;
    w_flush_act = 1'b0;
    for (int i = 0; i < NSTAGE; i++) begin
      if (flush_req[i] && r_v[i]) begin
        w_fk = FK_W'(i);
        w_flush_act = 1'b1;
      end
    end
  end

  // younger stages die; nothing loads at or behind the flusher
  always_comb begin
    w_kill = '0;
    w_load = '0;
    w_load[0] = in_valid & w_ready[0] & ~w_flush_act;
    for (int j = 0; j < NSTAGE; j++) begin
      w_kill[j] = w_flush_act && (j < int'(w_fk));
    end
    for (int j = 1; j < NSTAGE; j++) begin
      w_load[j] = w_fire[j-1] &
                  ~(w_flush_act && (j <= int'(w_fk)));
    end
  end

  assign in_ready    = rst & w_ready[0] & ~w_flush_act;
  assign load_en     = {NSTAGE{rst}} & w_load;
  assign fire        = {NSTAGE{rst}} & w_fire;
  assign kill        = {NSTAGE{rst}} & w_kill;
  assign stage_valid = r_v;

  // valid bits: kill beats load beats fire beats hold
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_v <= '0;
    end else begin
      r_v <= ~w_kill & (w_load | (r_v & ~w_fire));
    end
  end

  assign w_stall_inc = (|r_v) & ~fire[NSTAGE-1];

  perf_counter #(.CNT_W(CNT_W)) u_retire (
    .clk   (clk),
    .rst   (rst),
    .inc   (fire[NSTAGE-1]),
    .count (retire_cnt)
  );

  perf_counter #(.CNT_W(CNT_W)) u_stall (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_stall_inc),
    .count (stall_cnt)
  );

  perf_counter #(.CNT_W(CNT_W)) u_flush (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_flush_act),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with NSTAGE=5.
// Vector table plus bubble and reset sequences.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  stage_busy;
  logic [4:0]  hold_req;
  logic [4:0]  flush_req;
  logic [4:0]  stage_valid;
  logic [4:0]  load_en;
  logic [4:0]  fire;
  logic [4:0]  kill;
  logic [63:0] retire_cnt;
  logic [63:0] stall_cnt;
  logic [63:0] flush_cnt;

  int n_run = 0;
  int n_fail = 0;

  pipe_ctrl #(.NSTAGE(5), .CNT_W(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .stage_busy  (stage_busy),
    .hold_req    (hold_req),
    .flush_req   (flush_req),
    .stage_valid (stage_valid),
    .load_en     (load_en),
    .fire        (fire),
    .kill        (kill),
    .retire_cnt  (retire_cnt),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       r;
    logic       iv;
    logic [4:0] busy;
    logic [4:0] hold;
    logic [4:0] flush;
    logic [4:0] v;
    logic       rdy;
    logic [4:0] ld;
    logic [4:0] fr;
    logic [4:0] kl;
  } vec_t;

  vec_t tv [16];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic iv,
                       input logic [4:0] b,
                       input logic [4:0] h,
                       input logic [4:0] f);
    rst = r;
    in_valid = iv;
    stage_busy = b;
    hold_req = h;
    flush_req = f;
  endtask

  task automatic reset_fill(input logic [4:0] pat);
    @(negedge clk) drive(0, 0, 0, 0, 0);
    @(negedge clk) drive(0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk) drive(1, pat[k], 0, 0, 0);
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);

    //        r  iv busy      hold      flush     v         rdy ld        fr        kl
    tv[0]  = '{1'b0,1'b1,5'b00000,5'b00000,5'b00000,5'b00000,1'b0,5'b00000,5'b00000,5'b00000};
    tv[1]  = '{1'b0,1'b1,5'b00000,5'b00000,5'b00000,5'b00000,1'b0,5'b00000,5'b00000,5'b00000};
    tv[2]  = '{1'b1,1'b1,5'b00000,5'b00000,5'b00000,5'b00000,1'b1,5'b00001,5'b00000,5'b00000};
    tv[3]  = '{1'b1,1'b1,5'b00000,5'b00000,5'b00000,5'b00001,1'b1,5'b00011,5'b00001,5'b00000};
    tv[4]  = '{1'b1,1'b1,5'b00000,5'b00000,5'b00000,5'b00011,1'b1,5'b00111,5'b00011,5'b00000};
    tv[5]  = '{1'b1,1'b1,5'b00000,5'b00000,5'b00000,5'b00111,1'b1,5'b01111,5'b00111,5'b00000};
    tv[6]  = '{1'b1,1'b1,5'b00000,5'b00000,5'b00000,5'b01111,1'b1,5'b11111,5'b01111,5'b00000};
    tv[7]  = '{1'b1,1'b1,5'b00000,5'b00000,5'b00000,5'b11111,1'b1,5'b11111,5'b11111,5'b00000};
    tv[8]  = '{1'b1,1'b1,5'b10000,5'b00000,5'b00000,5'b11111,1'b0,5'b00000,5'b00000,5'b00000};
    tv[9]  = '{1'b1,1'b1,5'b10000,5'b00000,5'b00000,5'b11111,1'b0,5'b00000,5'b00000,5'b00000};
    tv[10] = '{1'b1,1'b1,5'b10000,5'b00000,5'b00000,5'b11111,1'b0,5'b00000,5'b00000,5'b00000};
    tv[11] = '{1'b1,1'b1,5'b00000,5'b00100,5'b00000,5'b11111,1'b0,5'b10000,5'b11000,5'b00000};
    tv[12] = '{1'b1,1'b1,5'b00000,5'b00000,5'b00000,5'b10111,1'b1,5'b01111,5'b10111,5'b00000};
    tv[13] = '{1'b1,1'b1,5'b00000,5'b00000,5'b00100,5'b01111,1'b0,5'b11000,5'b01111,5'b00011};
    tv[14] = '{1'b1,1'b1,5'b00000,5'b00000,5'b01100,5'b11000,1'b0,5'b10000,5'b11000,5'b00111};
    tv[15] = '{1'b1,1'b1,5'b00000,5'b00000,5'b00010,5'b10000,1'b1,5'b00001,5'b10000,5'b00000};

    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      drive(tv[n].r, tv[n].iv, tv[n].busy, tv[n].hold, tv[n].flush);
      #1;
      chk($sformatf("v[%0d]", n), 64'(stage_valid), 64'(tv[n].v));
      chk($sformatf("rdy[%0d]", n), 64'(in_ready), 64'(tv[n].rdy));
      chk($sformatf("ld[%0d]", n), 64'(load_en), 64'(tv[n].ld));
      chk($sformatf("fire[%0d]", n), 64'(fire), 64'(tv[n].fr));
      chk($sformatf("kill[%0d]", n), 64'(kill), 64'(tv[n].kl));
    end

    @(negedge clk) drive(1, 0, 0, 0, 0);
    #1;
    chk("tbl_v_end", 64'(stage_valid), 64'h01);
    chk("tbl_retire", retire_cnt, 64'd5);
    chk("tbl_stall", stall_cnt, 64'd8);
    chk("tbl_flush", flush_cnt, 64'd2);

    reset_fill(5'b11011);
    @(negedge clk) drive(1, 0, 5'b10000, 0, 0);
    #1;
    chk("bub_v", 64'(stage_valid), 64'b11011);
    chk("bub_fire", 64'(fire), 64'b00011);
    chk("bub_ld", 64'(load_en), 64'b00110);
    chk("bub_rdy", 64'(in_ready), 64'd1);
    @(negedge clk) drive(1, 0, 0, 0, 0);
    #1;
    chk("bub_v_next", 64'(stage_valid), 64'b11110);
    chk("bub_retire", retire_cnt, 64'd0);
    chk("bub_stall", stall_cnt, 64'd5);

    reset_fill(5'b11111);
    @(negedge clk) drive(0, 1, 5'b11111, 0, 5'b01000);
    #1;
    chk("rmid_v", 64'(stage_valid), 64'b11111);
    chk("rmid_rdy", 64'(in_ready), 64'd0);
    chk("rmid_ld", 64'(load_en), 64'd0);
    chk("rmid_fire", 64'(fire), 64'd0);
    chk("rmid_kill", 64'(kill), 64'd0);
    @(negedge clk) drive(1, 0, 0, 0, 0);
    #1;
    chk("rmid_v_next", 64'(stage_valid), 64'd0);
    chk("rmid_retire", retire_cnt, 64'd0);
    chk("rmid_stall", stall_cnt, 64'd0);
    chk("rmid_flush", flush_cnt, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
